aes_key_schedule: RTL

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_key_schedule_if.sv | 23 ++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_key_schedule.sv | 128 ++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round/key constants, Rcon table, key-schedule
// state encoding and the S-box byte substitution function.
package aes_pkg;

  localparam int AES_NR       = 10;
  localparam int AES_NK       = 4;
  localparam int AES_KEY_BITS = 32 * AES_NK;

  // Round constants, indexed by round number. Entry 0 and 11..15 are padding
  // so that any 4-bit round index selects a defined value.
  localparam logic [7:0] AES_RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_DONE   = 2'd2
  } ks_state_t;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] p;
    x = a;
    y = b;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (x^254, which maps 0 to 0) followed by the
  // affine transform. Being a pure function of 8 bits, synthesis folds it
  // into a 256-entry lookup.
  function automatic logic [7:0] aes_sbox_fn(input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] inv;
    p   = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Key-load handshake and round-key read port between the upstream key
// source / cipher (master) and the key schedule (slave).
interface aes_key_schedule_if;
  import aes_pkg::*;

  logic                    key_valid;
  logic [AES_KEY_BITS-1:0] key;
  logic                    key_ready;
  logic                    rk_valid;
  logic [3:0]              rk_addr;
  logic [AES_KEY_BITS-1:0] rk_data;

  modport master (
    output key_valid, key, rk_addr,
    input  key_ready, rk_valid, rk_data
  );

  modport slave (
    input  key_valid, key, rk_addr,
    output key_ready, rk_valid, rk_data
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES byte substitution; also used by the cipher's sub_bytes.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] plain,
  output logic [7:0] subst
);

  assign subst = aes_sbox_fn(plain);

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: one round key per cycle through a single SubWord,
// all 11 round keys kept in a register array with a registered read port.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  aes_key_schedule_if.slave ks
);

  ks_state_t               state_reg;
  ks_state_t               state_next;
  logic [3:0]              round_reg;
  logic [3:0]              round_next;
  logic                    rk_valid_reg;
  logic [AES_KEY_BITS-1:0] rk_data_reg;
  logic [AES_KEY_BITS-1:0] prev_key_reg;
  logic [AES_KEY_BITS-1:0] rk_mem [AES_NR+1];

  logic                    transfer;
  logic                    wr_en;
  logic [3:0]              wr_addr;
  logic [AES_KEY_BITS-1:0] wr_data;

  logic [31:0]             rot_word;
  logic [31:0]             sub_word;
  logic [31:0]             w0_next;
  logic [31:0]             w1_next;
  logic [31:0]             w2_next;
  logic [31:0]             w3_next;
  logic [AES_KEY_BITS-1:0] next_rk;

  // Reset forces key_ready low so no key can be taken while rst_n is asserted.
  assign ks.key_ready = rst_n && (state_reg != KS_EXPAND);
  assign ks.rk_valid  = rk_valid_reg;
  assign ks.rk_data   = rk_data_reg;
  assign transfer     = ks.key_valid && ks.key_ready;

  // RotWord of w3 (the low word of the previous round key).
  assign rot_word = {prev_key_reg[23:0], prev_key_reg[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .plain (rot_word[8*gi +: 8]),
        .subst (sub_word[8*gi +: 8])
      );
    end
  endgenerate

  assign w0_next = prev_key_reg[127:96] ^ sub_word ^ {AES_RCON[round_reg], 24'h000000};
  assign w1_next = prev_key_reg[95:64]  ^ w0_next;
  assign w2_next = prev_key_reg[63:32]  ^ w1_next;
  assign w3_next = prev_key_reg[31:0]   ^ w2_next;
  assign next_rk = {w0_next, w1_next, w2_next, w3_next};

  // Next-state logic and round-key write selection.
  always_comb begin
    state_next = state_reg;
    round_next = round_reg;
    wr_en      = 1'b0;
    wr_addr    = 4'd0;
    wr_data    = next_rk;
    case (state_reg)
      KS_IDLE, KS_DONE: begin
        if (transfer) begin
          wr_en      = 1'b1;
          wr_addr    = 4'd0;
          wr_data    = ks.key;
          round_next = 4'd1;
          state_next = KS_EXPAND;
        end
      end
      KS_EXPAND: begin
        wr_en   = 1'b1;
        wr_addr = round_reg;
        wr_data = next_rk;
        if (round_reg == 4'(AES_NR)) begin
          round_next = 4'd0;
          state_next = KS_DONE;
        end else begin
          round_next = round_reg + 4'd1;
        end
      end
      default: begin
        state_next = KS_IDLE;
        round_next = 4'd0;
      end
    endcase
  end

  // State, round counter and valid flag. rk_valid is registered off the DONE
  // state, so it rises one cycle after slot 10 is written (11 cycles after the
  // key transfer) and drops on the cycle after a new key is taken in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= KS_IDLE;
      round_reg    <= 4'd0;
      rk_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      round_reg    <= round_next;
      rk_valid_reg <= (state_reg == KS_DONE) && !transfer;
    end
  end

  // Round-key storage; contents are meaningless until rk_valid, so no reset.
  // prev_key_reg mirrors the last slot written and feeds the next round.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      rk_mem[wr_addr] <= wr_data;
      prev_key_reg    <= wr_data;
    end
  end

  // Registered read port; addresses beyond round 10 read as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rk_data_reg <= '0;
    end else if (ks.rk_addr <= 4'(AES_NR)) begin
      rk_data_reg <= rk_mem[ks.rk_addr];
    end else begin
      rk_data_reg <= '0;
    end
  end

endmodule
